// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// ------------------
// Shares the register file's single write port between two writeback sources:
// ALU results (source A) and load data (source B). At most one request is
// accepted per cycle over a valid/ready handshake. The accepted write is
// registered onto WRITE_ENABLE/WRITE_REG/WRITE_DATA and also forwarded to
// both read ports through the bypass outputs while it is in flight.
//
// Parameters:
//   DATA_WIDTH    - write data width
//   ADDR_WIDTH    - register index width
//   PRIORITY_MODE - 0: round-robin between A and B, 1: fixed, B wins
//   COUNT_WIDTH   - width of the saturating collision counter
//
// Ports:
//   CLK, RST                     - clock, synchronous active-high reset
//   A_VALID/A_REG/A_DATA/A_READY - ALU writeback handshake (READY combinational)
//   B_VALID/B_REG/B_DATA/B_READY - load writeback handshake (READY combinational)
//   WRITE_ENABLE/REG/DATA        - registered write to register_file
//   READ_REG_1/2                 - read addresses presented to register_file
//   BYP_HIT_1/2, BYP_DATA_1/2    - in-flight write forwarding (combinational)
//   COLLISION_COUNT              - cycles with both sources valid, saturating
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int PRIORITY_MODE = 0,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   A_VALID,
  input  logic [ADDR_WIDTH-1:0]  A_REG,
  input  logic [DATA_WIDTH-1:0]  A_DATA,
  output logic                   A_READY,
  input  logic                   B_VALID,
  input  logic [ADDR_WIDTH-1:0]  B_REG,
  input  logic [DATA_WIDTH-1:0]  B_DATA,
  output logic                   B_READY,
  output logic                   WRITE_ENABLE,
  output logic [ADDR_WIDTH-1:0]  WRITE_REG,
  output logic [DATA_WIDTH-1:0]  WRITE_DATA,
  input  logic [ADDR_WIDTH-1:0]  READ_REG_1,
  input  logic [ADDR_WIDTH-1:0]  READ_REG_2,
  output logic                   BYP_HIT_1,
  output logic                   BYP_HIT_2,
  output logic [DATA_WIDTH-1:0]  BYP_DATA_1,
  output logic [DATA_WIDTH-1:0]  BYP_DATA_2,
  output logic [COUNT_WIDTH-1:0] COLLISION_COUNT
);

  localparam logic [ADDR_WIDTH-1:0]  REG_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0]  DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam bit                     FIXED_B   = (PRIORITY_MODE != 32'sd0);

  logic                   grant_a_s;
  logic                   grant_b_s;
  logic [ADDR_WIDTH-1:0]  win_reg_s;
  logic [DATA_WIDTH-1:0]  win_data_s;
  logic                   we_r;
  logic [ADDR_WIDTH-1:0]  wreg_r;
  logic [DATA_WIDTH-1:0]  wdata_r;
  logic                   ptr_r;    // 0: A favoured on contention, 1: B favoured
  logic [COUNT_WIDTH-1:0] count_r;

  // Grant selection; nothing is accepted during a reset cycle.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (RST) begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end else if (A_VALID && B_VALID) begin
      if (FIXED_B || ptr_r) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b1;
      end
    end else if (A_VALID) begin
      grant_a_s = 1'b1;
    end else if (B_VALID) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Winner's destination and data.
  always_comb begin
    win_reg_s  = A_REG;
    win_data_s = A_DATA;
    if (grant_b_s) begin
      win_reg_s  = B_REG;
      win_data_s = B_DATA;
    end else begin
      win_reg_s  = A_REG;
      win_data_s = A_DATA;
    end
  end

  // Write register, round-robin pointer and collision counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      we_r    <= 1'b0;
      wreg_r  <= REG_ZERO;
      wdata_r <= DATA_ZERO;
      ptr_r   <= 1'b0;
      count_r <= {COUNT_WIDTH{1'b0}};
    end else begin
      // Writes to x0 complete the handshake but are dropped; REG/DATA then hold.
      if ((grant_a_s || grant_b_s) && (win_reg_s != REG_ZERO)) begin
        we_r    <= 1'b1;
        wreg_r  <= win_reg_s;
        wdata_r <= win_data_s;
      end else begin
        we_r    <= 1'b0;
      end

      if (FIXED_B) begin
        ptr_r <= 1'b0;
      end else if (grant_a_s) begin
        ptr_r <= 1'b1;
      end else if (grant_b_s) begin
        ptr_r <= 1'b0;
      end else begin
        ptr_r <= ptr_r;
      end

      if (A_VALID && B_VALID && (count_r != CNT_MAX)) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign A_READY         = grant_a_s;
  assign B_READY         = grant_b_s;
  assign WRITE_ENABLE    = we_r;
  assign WRITE_REG       = wreg_r;
  assign WRITE_DATA      = wdata_r;
  assign COLLISION_COUNT = count_r;

  // Forward the in-flight write; x0 never hits.
  always_comb begin
    BYP_HIT_1  = we_r && (READ_REG_1 == wreg_r) && (READ_REG_1 != REG_ZERO);
    BYP_HIT_2  = we_r && (READ_REG_2 == wreg_r) && (READ_REG_2 != REG_ZERO);
    BYP_DATA_1 = BYP_HIT_1 ? wdata_r : DATA_ZERO;
    BYP_DATA_2 = BYP_HIT_2 ? wdata_r : DATA_ZERO;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: three instances (round-robin, fixed priority,
// round-robin with a 4-bit counter) share one stimulus stream. A behavioural
// model per instance predicts every output on every checked cycle, and a few
// hand-computed expectations pin the directed scenarios.
module tb_regfile_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        A_VALID = 1'b0;
  logic [4:0]  A_REG = 5'd0;
  logic [31:0] A_DATA = 32'd0;
  logic        B_VALID = 1'b0;
  logic [4:0]  B_REG = 5'd0;
  logic [31:0] B_DATA = 32'd0;
  logic [4:0]  READ_REG_1 = 5'd0;
  logic [4:0]  READ_REG_2 = 5'd0;

  logic        a_rdy [3];
  logic        b_rdy [3];
  logic        we    [3];
  logic [4:0]  wreg  [3];
  logic [31:0] wdata [3];
  logic        hit1  [3];
  logic        hit2  [3];
  logic [31:0] bd1   [3];
  logic [31:0] bd2   [3];
  logic [15:0] cnt   [3];
  logic [15:0] cnt0_s, cnt1_s;
  logic [3:0]  cnt2_s;

  always_comb begin
    cnt[0] = cnt0_s;
    cnt[1] = cnt1_s;
    cnt[2] = {12'd0, cnt2_s};
  end

  always #5 CLK = ~CLK;

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .PRIORITY_MODE(0), .COUNT_WIDTH(16)) dut0 (
    .CLK(CLK), .RST(RST),
    .A_VALID(A_VALID), .A_REG(A_REG), .A_DATA(A_DATA), .A_READY(a_rdy[0]),
    .B_VALID(B_VALID), .B_REG(B_REG), .B_DATA(B_DATA), .B_READY(b_rdy[0]),
    .WRITE_ENABLE(we[0]), .WRITE_REG(wreg[0]), .WRITE_DATA(wdata[0]),
    .READ_REG_1(READ_REG_1), .READ_REG_2(READ_REG_2),
    .BYP_HIT_1(hit1[0]), .BYP_HIT_2(hit2[0]), .BYP_DATA_1(bd1[0]), .BYP_DATA_2(bd2[0]),
    .COLLISION_COUNT(cnt0_s));

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .PRIORITY_MODE(1), .COUNT_WIDTH(16)) dut1 (
    .CLK(CLK), .RST(RST),
    .A_VALID(A_VALID), .A_REG(A_REG), .A_DATA(A_DATA), .A_READY(a_rdy[1]),
    .B_VALID(B_VALID), .B_REG(B_REG), .B_DATA(B_DATA), .B_READY(b_rdy[1]),
    .WRITE_ENABLE(we[1]), .WRITE_REG(wreg[1]), .WRITE_DATA(wdata[1]),
    .READ_REG_1(READ_REG_1), .READ_REG_2(READ_REG_2),
    .BYP_HIT_1(hit1[1]), .BYP_HIT_2(hit2[1]), .BYP_DATA_1(bd1[1]), .BYP_DATA_2(bd2[1]),
    .COLLISION_COUNT(cnt1_s));

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .PRIORITY_MODE(0), .COUNT_WIDTH(4)) dut2 (
    .CLK(CLK), .RST(RST),
    .A_VALID(A_VALID), .A_REG(A_REG), .A_DATA(A_DATA), .A_READY(a_rdy[2]),
    .B_VALID(B_VALID), .B_REG(B_REG), .B_DATA(B_DATA), .B_READY(b_rdy[2]),
    .WRITE_ENABLE(we[2]), .WRITE_REG(wreg[2]), .WRITE_DATA(wdata[2]),
    .READ_REG_1(READ_REG_1), .READ_REG_2(READ_REG_2),
    .BYP_HIT_1(hit1[2]), .BYP_HIT_2(hit2[2]), .BYP_DATA_1(bd1[2]), .BYP_DATA_2(bd2[2]),
    .COLLISION_COUNT(cnt2_s));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          mode_k [3] = '{0, 1, 0};
  int          cmax_k [3] = '{65535, 65535, 15};
  bit          m_we    [3];
  logic [4:0]  m_wreg  [3];
  logic [31:0] m_wdata [3];
  bit          m_last_a [3];   // most recent grant went to A, so B is favoured next
  int          m_cnt   [3];

  // 0: none, 1: A, 2: B
  function automatic int exp_grant(int k);
    if (RST) return 0;
    if (A_VALID && B_VALID) return (mode_k[k] == 1 || m_last_a[k]) ? 2 : 1;
    if (A_VALID) return 1;
    if (B_VALID) return 2;
    return 0;
  endfunction

  always @(posedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      int g;
      g = exp_grant(k);
      if (RST) begin
        m_we[k] = 1'b0; m_wreg[k] = 5'd0; m_wdata[k] = 32'd0;
        m_last_a[k] = 1'b0; m_cnt[k] = 0;
      end else begin
        logic [4:0]  dst;
        logic [31:0] dat;
        dst = (g == 2) ? B_REG : A_REG;
        dat = (g == 2) ? B_DATA : A_DATA;
        if (g != 0 && dst != 5'd0) begin
          m_we[k] = 1'b1; m_wreg[k] = dst; m_wdata[k] = dat;
        end else begin
          m_we[k] = 1'b0;
        end
        if (mode_k[k] == 0 && g != 0) m_last_a[k] = (g == 1);
        if (A_VALID && B_VALID && m_cnt[k] < cmax_k[k]) m_cnt[k] = m_cnt[k] + 1;
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        int g;
        bit h1, h2;
        g  = exp_grant(k);
        h1 = m_we[k] && (READ_REG_1 == m_wreg[k]) && (READ_REG_1 != 5'd0);
        h2 = m_we[k] && (READ_REG_2 == m_wreg[k]) && (READ_REG_2 != 5'd0);
        chk($sformatf("a_ready%0d", k), a_rdy[k], (g == 1));
        chk($sformatf("b_ready%0d", k), b_rdy[k], (g == 2));
        chk($sformatf("we%0d", k), we[k], m_we[k]);
        chk($sformatf("wreg%0d", k), wreg[k], m_wreg[k]);
        chk($sformatf("wdata%0d", k), wdata[k], m_wdata[k]);
        chk($sformatf("hit1_%0d", k), hit1[k], h1);
        chk($sformatf("hit2_%0d", k), hit2[k], h2);
        chk($sformatf("byp1_%0d", k), bd1[k], h1 ? m_wdata[k] : 32'd0);
        chk($sformatf("byp2_%0d", k), bd2[k], h2 ? m_wdata[k] : 32'd0);
        chk($sformatf("count%0d", k), cnt[k], m_cnt[k]);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ra, rb, hold_a, hold_b;
    // Reset with A requesting x1.
    RST = 1'b1; A_VALID = 1'b1; A_REG = 5'd1; A_DATA = 32'hAAAA_AAAA;
    READ_REG_1 = 5'd1; READ_REG_2 = 5'd0;
    cyc();
    chk_en = 1'b1;
    settle();
    cyc();
    settle();
    chk("rst_a_ready", a_rdy[0], 32'd0);
    chk("rst_we", we[0], 32'd0);
    chk("rst_count", cnt[0], 32'd0);

    // Single write: accepted the cycle reset falls, visible via bypass next cycle.
    cyc(); RST = 1'b0;
    settle();
    chk("single_a_ready", a_rdy[0], 32'd1);
    cyc(); A_VALID = 1'b0;
    settle();
    chk("single_we", we[0], 32'd1);
    chk("single_wreg", wreg[0], 32'd1);
    chk("single_hit1", hit1[0], 32'd1);
    chk("single_byp1", bd1[0], 32'hAAAA_AAAA);

    // x0 write is accepted and dropped.
    cyc(); B_VALID = 1'b1; B_REG = 5'd0; B_DATA = 32'hFFFF_FFFF;
    settle();
    chk("x0_b_ready", b_rdy[0], 32'd1);
    cyc(); B_VALID = 1'b0;
    settle();
    chk("x0_we", we[0], 32'd0);
    chk("x0_hit2", hit2[0], 32'd0);

    // Round-robin from reset.
    cyc(); RST = 1'b1;
    settle();
    cyc(); RST = 1'b0;
    A_VALID = 1'b1; A_REG = 5'd2; A_DATA = 32'h5555_5555;
    B_VALID = 1'b1; B_REG = 5'd3; B_DATA = 32'h1234_5678;
    ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        cyc();
        if (ra) A_DATA = A_DATA + 32'd1;
        if (rb) B_DATA = B_DATA + 32'd1;
      end
      settle();
      ra = a_rdy[0]; rb = b_rdy[0];
      chk("rr_a_ready", a_rdy[0], (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_b_ready", b_rdy[0], (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) chk("rr_wreg", wreg[0], ((i - 1) % 2 == 0) ? 32'd2 : 32'd3);
    end
    cyc(); A_VALID = 1'b0; B_VALID = 1'b0;
    settle();
    chk("rr_last_wreg", wreg[0], 32'd3);
    chk("rr_count", cnt[0], 32'd4);

    // Fixed priority on instance 1.
    cyc(); RST = 1'b1;
    settle();
    cyc(); RST = 1'b0;
    A_VALID = 1'b1; A_REG = 5'd4; A_DATA = 32'h0000_0044;
    B_VALID = 1'b1; B_REG = 5'd5; B_DATA = 32'h0000_0050;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        cyc();
        B_DATA = B_DATA + 32'd1;
      end
      settle();
      chk("fix_b_ready", b_rdy[1], 32'd1);
      chk("fix_a_ready", a_rdy[1], 32'd0);
    end
    cyc(); B_VALID = 1'b0;
    settle();
    chk("fix_a_after", a_rdy[1], 32'd1);

    // Saturation on the 4-bit counter, then reset while a write is in flight.
    cyc(); RST = 1'b1;
    settle();
    cyc(); RST = 1'b0;
    A_VALID = 1'b1; A_REG = 5'd6; A_DATA = 32'h0000_0066;
    B_VALID = 1'b1; B_REG = 5'd7; B_DATA = 32'h0000_0077;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) cyc();
      settle();
    end
    cyc();
    settle();
    chk("sat_count", cnt[2], 32'd15);
    cyc();
    settle();
    chk("sat_hold", cnt[2], 32'd15);
    chk("sat_we", we[2], 32'd1);
    cyc(); RST = 1'b1;
    settle();
    chk("rstmid_a_ready", a_rdy[2], 32'd0);
    chk("rstmid_b_ready", b_rdy[2], 32'd0);
    cyc(); RST = 1'b0; A_VALID = 1'b0; B_VALID = 1'b0;
    settle();
    chk("rstmid_we", we[2], 32'd0);
    chk("rstmid_count", cnt[2], 32'd0);

    // Randomised traffic; losers on instance 0 hold their request.
    hold_a = 1'b0; hold_b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      RST = ($urandom_range(0, 63) == 0);
      if (!hold_a) begin
        A_VALID = $urandom_range(0, 2) != 0;
        A_REG   = 5'($urandom_range(0, 7));
        A_DATA  = $urandom;
      end
      if (!hold_b) begin
        B_VALID = $urandom_range(0, 2) != 0;
        B_REG   = 5'($urandom_range(0, 7));
        B_DATA  = $urandom;
      end
      READ_REG_1 = 5'($urandom_range(0, 7));
      READ_REG_2 = 5'($urandom_range(0, 7));
      settle();
      hold_a = A_VALID && !a_rdy[0];
      hold_b = B_VALID && !b_rdy[0];
    end

    cyc();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Arbitrates the register file's single write port between two writeback sources: ALU results (source A) and load data (source B). Accepts at most one write per cycle over valid/ready handshakes and drives a registered WRITE_ENABLE/WRITE_REG/WRITE_DATA into `register_file`. Provides a bypass of the in-flight write to both read ports and a saturating collision counter for performance monitoring.

## Interface
- DATA_WIDTH, 32, width of write data
- ADDR_WIDTH, 5, register index width
- PRIORITY_MODE, 0, 0 = round-robin between A and B; 1 = fixed, B wins
- COUNT_WIDTH, 16, width of the collision counter

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset; synchronous, active-high
- A_VALID  in  1  ALU writeback request
- A_REG  in  ADDR_WIDTH  ALU destination register
- A_DATA  in  DATA_WIDTH  ALU result
- A_READY  out  1  A accepted this cycle (combinational)
- B_VALID  in  1  load writeback request
- B_REG  in  ADDR_WIDTH  load destination register
- B_DATA  in  DATA_WIDTH  load data
- B_READY  out  1  B accepted this cycle (combinational)
- WRITE_ENABLE  out  1  to register_file, registered
- WRITE_REG  out  ADDR_WIDTH  to register_file, registered
- WRITE_DATA  out  DATA_WIDTH  to register_file, registered
- READ_REG_1, READ_REG_2  in  ADDR_WIDTH  read addresses currently presented to register_file
- BYP_HIT_1, BYP_HIT_2  out  1  in-flight write targets that read address (combinational)
- BYP_DATA_1, BYP_DATA_2  out  DATA_WIDTH  WRITE_DATA when the matching hit is 1, else 0
- COLLISION_COUNT  out  COUNT_WIDTH  cycles with both sources valid, saturating

## Operation
- State: output write register (enable/reg/data), round-robin pointer PTR (0 = A favoured, 1 = B favoured), COLLISION_COUNT.
- Grant, evaluated every cycle when RST=0:
  - Only A valid: grant A. Only B valid: grant B. Neither: no grant.
  - Both valid, PRIORITY_MODE=0: grant the source named by PTR. PRIORITY_MODE=1: grant B.
- X_READY = grant to X. At most one of A_READY and B_READY is 1. The loser must hold VALID/REG/DATA stable until it is granted.
- PTR update (mode 0 only): after a grant to A, PTR becomes 1; after a grant to B, PTR becomes 0; no grant leaves PTR unchanged. In mode 1, PTR holds 0.
- On a grant with destination != 0: next cycle WRITE_ENABLE=1, WRITE_REG/WRITE_DATA = the winner's REG/DATA.
- On a grant with destination == 0: the handshake completes (READY=1), the write is dropped, and WRITE_ENABLE=0 next cycle. This matches x0 being hardwired to zero.
- No grant: WRITE_ENABLE=0 next cycle; WRITE_REG and WRITE_DATA hold their previous values.
- Bypass: BYP_HIT_n = WRITE_ENABLE && (READ_REG_n == WRITE_REG) && (READ_REG_n != 0).
- COLLISION_COUNT increments by 1 in each cycle where A_VALID && B_VALID && !RST. It saturates at 2^COUNT_WIDTH-1 and does not wrap.
- Ordering across sources to the same register follows grant order. The issuing pipeline is responsible for correct cross-source ordering.

## Timing
- Reset (sampled on CLK edge): WRITE_ENABLE=0, WRITE_REG=0, WRITE_DATA=0, PTR=0, COLLISION_COUNT=0.
- While RST=1: A_READY=B_READY=0, so no request is accepted in a reset cycle. BYP_HIT_n follows the registered state and is 0 from the first cycle after the reset edge.
- Reset mid-operation: a write in flight (WRITE_ENABLE=1) is cleared at the reset edge and never reaches the register file after that edge. Held requests are re-arbitrated after RST falls, with PTR=0.
- Latency: acceptance in cycle N gives WRITE_ENABLE=1 in cycle N+1. The register file captures the write at the end of N+1, and the value is readable from the file in N+2. During N+1 the value is available only via the bypass.
- Throughput: one write per cycle sustained.
- Under continuous contention in mode 0, grants strictly alternate and neither source waits more than 1 cycle.

## Test plan
- Reset: RST=1 for 2 cycles with A_VALID=1, A_REG=1 -> A_READY=0, WRITE_ENABLE=0, COLLISION_COUNT=0. After RST falls, A is granted the same cycle.
- Single write: A writes x1=0xAAAA_AAAA in cycle N -> A_READY=1 in N. In N+1: WRITE_ENABLE=1, WRITE_REG=1, and with READ_REG_1=1, BYP_HIT_1=1 and BYP_DATA_1=0xAAAA_AAAA. register_file READ_DATA_1=0xAAAA_AAAA in N+2.
- x0 drop: B writes x0=0xFFFF_FFFF -> B_READY=1, WRITE_ENABLE stays 0; with READ_REG_2=0, BYP_HIT_2=0 and the register file reads x0 as 0.
- Round-robin: mode 0, both sources valid for 4 cycles from reset (A to x2 = 0x5555_5555, B to x3 = 0x1234_5678, each presenting new data after acceptance) -> grant order A, B, A, B; WRITE_REG sequence 2, 3, 2, 3; COLLISION_COUNT=4.
- Fixed priority: PRIORITY_MODE=1, both valid for 3 cycles, then B_VALID=0 -> B granted 3 times with A_READY=0 throughout, then A granted the next cycle.
- Saturation and reset mid-write: COUNT_WIDTH=4 with 20 collision cycles -> COLLISION_COUNT=15 and holds. Then assert RST while WRITE_ENABLE=1 -> next cycle WRITE_ENABLE=0 and COLLISION_COUNT=0.
